// File: rtl/tmr_recovery_ctrl_pkg.sv
// Shared definitions for the TMR recovery controller: FSM encodings, core IDs,
// register-file geometry and small voter-decoding helpers.
package tmr_recovery_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESYNC   = 3'd1,
        ST_PCLOAD   = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_ROLLBACK = 3'd4,
        ST_FATAL    = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] CORE_A = 2'd0;
    localparam logic [1:0] CORE_B = 2'd1;
    localparam logic [1:0] CORE_C = 2'd2;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);
    localparam logic [REG_ADDR_W-1:0] REG_ADDR_FIRST = REG_ADDR_W'(1'b1);
    localparam logic [REG_ADDR_W-1:0] REG_ADDR_LAST  = REG_ADDR_W'(REG_COUNT - 1);

    // One-hot destination mask ordered {A,B,C}
    function automatic logic [2:0] core_onehot(input logic [1:0] core_id);
        logic [2:0] mask;
        case (core_id)
            CORE_A:  mask = 3'b100;
            CORE_B:  mask = 3'b010;
            CORE_C:  mask = 3'b001;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

    // Agreement patterns with no single identifiable faulty core
    function automatic logic is_multi_disagree(input logic [2:0] voter_state);
        logic hit;
        case (voter_state)
            3'b000, 3'b011, 3'b101, 3'b110: hit = 1'b1;
            default:                        hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/tmr_retry_counter.sv
// Counts recoveries since the last clean window; a run of CLEAN_WIN clean
// IDLE cycles forgives all previous recoveries.
module tmr_retry_counter #(
    parameter int RETRY_LIMIT = 3,
    parameter int CLEAN_WIN   = 16
) (
    input  logic clk,
    input  logic rst_in,
    input  logic inc,
    input  logic clean,
    output logic at_limit
);
    localparam int RW = $clog2(RETRY_LIMIT + 1);
    localparam int CW = $clog2(CLEAN_WIN + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);
    localparam logic [RW-1:0] RETRY_ONE = RW'(1'b1);
    localparam logic [CW-1:0] CLEAN_END = CW'(CLEAN_WIN - 1);
    localparam logic [CW-1:0] CLEAN_ONE = CW'(1'b1);

    logic [RW-1:0] retry_r;
    logic [CW-1:0] clean_r;

    // Retry counter saturates at the limit; clean-run counter restarts on any unclean cycle
    always_ff @(posedge clk) begin
        if (rst_in) begin
            retry_r <= '0;
            clean_r <= '0;
        end else if (inc) begin
            clean_r <= '0;
            if (retry_r != RETRY_MAX) begin
                retry_r <= retry_r + RETRY_ONE;
            end else begin
                retry_r <= retry_r;
            end
        end else if (clean) begin
            if (clean_r == CLEAN_END) begin
                clean_r <= '0;
                retry_r <= '0;
            end else begin
                clean_r <= clean_r + CLEAN_ONE;
            end
        end else begin
            clean_r <= '0;
        end
    end

    assign at_limit = (retry_r == RETRY_MAX);

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Recovery sequencer for a triple-modular-redundant core cluster: resyncs a single
// faulty core's register file or rolls all cores back, and escalates to a sticky fatal state.
module tmr_recovery_ctrl
    import tmr_recovery_ctrl_pkg::*;
#(
    parameter int RETRY_LIMIT = 3,
    parameter int CLEAN_WIN   = 16
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic [2:0]            Voter_state,
    input  logic                  Recovery_mode,
    input  logic [31:0]           PC_Top,
    input  logic [31:0]           PC_Top_rollback,
    output logic                  Stall,
    output logic                  Resync_en,
    output logic [REG_ADDR_W-1:0] Resync_addr,
    output logic [1:0]            Resync_src,
    output logic [2:0]            Resync_dst,
    output logic                  PC_load,
    output logic [31:0]           PC_load_value,
    output logic [7:0]            Fault_count,
    output logic                  Fatal,
    output logic [2:0]            Ctrl_state
);
    ctrl_state_e           state_r, state_nx_s;
    logic [REG_ADDR_W-1:0] addr_r, addr_nx_s;
    logic [1:0]            src_r, src_nx_s, faulty_s;
    logic [2:0]            dst_r;
    logic [31:0]           pc_r, pc_nx_s;
    logic [7:0]            fault_cnt_r;
    logic                  stall_r, en_r, load_r, fatal_r;
    logic                  detect_s, latch_s, clean_s, at_limit_s;

    assign clean_s = (state_r == ST_IDLE) && (Voter_state == 3'b111) && !Recovery_mode;

    tmr_retry_counter #(
        .RETRY_LIMIT(RETRY_LIMIT),
        .CLEAN_WIN  (CLEAN_WIN)
    ) u_retry (
        .clk     (clk),
        .rst_in  (rst_in),
        .inc     (detect_s),
        .clean   (clean_s),
        .at_limit(at_limit_s)
    );

    // Next-state logic; voter inputs are only looked at while IDLE
    always_comb begin
        state_nx_s = state_r;
        addr_nx_s  = addr_r;
        src_nx_s   = src_r;
        pc_nx_s    = pc_r;
        faulty_s   = CORE_A;
        detect_s   = 1'b0;
        latch_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Recovery_mode || is_multi_disagree(Voter_state)) begin
                    detect_s = 1'b1;
                    pc_nx_s  = PC_Top_rollback;
                    if (at_limit_s) begin
                        state_nx_s = ST_FATAL;
                    end else begin
                        state_nx_s = ST_ROLLBACK;
                        latch_s    = 1'b1;
                    end
                end else if (Voter_state != 3'b111) begin
                    detect_s = 1'b1;
                    pc_nx_s  = PC_Top;
                    case (Voter_state)
                        3'b100:  begin faulty_s = CORE_C; src_nx_s = CORE_A; end
                        3'b010:  begin faulty_s = CORE_A; src_nx_s = CORE_B; end
                        default: begin faulty_s = CORE_B; src_nx_s = CORE_A; end
                    endcase
                    if (at_limit_s) begin
                        state_nx_s = ST_FATAL;
                    end else begin
                        state_nx_s = ST_RESYNC;
                        addr_nx_s  = REG_ADDR_FIRST;
                        latch_s    = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RESYNC: begin
                if (addr_r == REG_ADDR_LAST) begin
                    state_nx_s = ST_PCLOAD;
                    addr_nx_s  = '0;
                end else begin
                    addr_nx_s = addr_r + REG_ADDR_FIRST;
                end
            end
            ST_PCLOAD:   state_nx_s = ST_SETTLE;
            ST_ROLLBACK: state_nx_s = ST_SETTLE;
            ST_SETTLE:   state_nx_s = ST_IDLE;
            ST_FATAL:    state_nx_s = ST_FATAL;
            default:     state_nx_s = ST_IDLE;
        endcase
    end

    // State, latches and output registers (outputs are decoded from the next state)
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            src_r       <= 2'd0;
            dst_r       <= 3'd0;
            pc_r        <= 32'd0;
            fault_cnt_r <= 8'd0;
            stall_r     <= 1'b0;
            en_r        <= 1'b0;
            load_r      <= 1'b0;
            fatal_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            addr_r  <= addr_nx_s;
            stall_r <= (state_nx_s != ST_IDLE);
            en_r    <= (state_nx_s == ST_RESYNC);
            load_r  <= (state_nx_s == ST_PCLOAD) || (state_nx_s == ST_ROLLBACK);
            fatal_r <= fatal_r || (state_nx_s == ST_FATAL);
            if (latch_s) begin
                src_r <= src_nx_s;
                dst_r <= (state_nx_s == ST_RESYNC) ? core_onehot(faulty_s) : dst_r;
                pc_r  <= pc_nx_s;
            end else begin
                src_r <= src_r;
                dst_r <= dst_r;
                pc_r  <= pc_r;
            end
            if (detect_s && (fault_cnt_r != 8'hFF)) begin
                fault_cnt_r <= fault_cnt_r + 8'd1;
            end else begin
                fault_cnt_r <= fault_cnt_r;
            end
        end
    end

    assign Stall         = stall_r;
    assign Resync_en     = en_r;
    assign Resync_addr   = addr_r;
    assign Resync_src    = src_r;
    assign Resync_dst    = dst_r;
    assign PC_load       = load_r;
    assign PC_load_value = pc_r;
    assign Fault_count   = fault_cnt_r;
    assign Fatal         = fatal_r;
    assign Ctrl_state    = state_r;

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Directed and randomized bench for tmr_recovery_ctrl against a transaction-level
// model of recovery sequences, fault counting and retry escalation.
module tb_tmr_recovery_ctrl;
    import tmr_recovery_ctrl_pkg::*;

    localparam int RETRY_LIMIT = 3;
    localparam int CLEAN_WIN   = 16;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [2:0]  Voter_state;
    logic        Recovery_mode;
    logic [31:0] PC_Top, PC_Top_rollback;
    logic        Stall, Resync_en, PC_load, Fatal;
    logic [4:0]  Resync_addr;
    logic [1:0]  Resync_src;
    logic [2:0]  Resync_dst, Ctrl_state;
    logic [31:0] PC_load_value;
    logic [7:0]  Fault_count;

    tmr_recovery_ctrl #(.RETRY_LIMIT(RETRY_LIMIT), .CLEAN_WIN(CLEAN_WIN)) dut (
        .clk(clk), .rst_in(rst_in), .Voter_state(Voter_state), .Recovery_mode(Recovery_mode),
        .PC_Top(PC_Top), .PC_Top_rollback(PC_Top_rollback), .Stall(Stall),
        .Resync_en(Resync_en), .Resync_addr(Resync_addr), .Resync_src(Resync_src),
        .Resync_dst(Resync_dst), .PC_load(PC_load), .PC_load_value(PC_load_value),
        .Fault_count(Fault_count), .Fatal(Fatal), .Ctrl_state(Ctrl_state)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: recovery bookkeeping at transaction level
    int          m_retry, m_clean, m_fc;
    bit          m_fatal;
    logic [1:0]  m_src;
    logic [2:0]  m_dst;
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input bit stall, input bit en,
                              input int addr, input bit ld);
        chk({tag, ".stall"}, Stall, stall);
        chk({tag, ".en"}, Resync_en, en);
        chk({tag, ".addr"}, Resync_addr, addr);
        chk({tag, ".load"}, PC_load, ld);
        chk({tag, ".src"}, Resync_src, m_src);
        chk({tag, ".dst"}, Resync_dst, m_dst);
        chk({tag, ".pcval"}, PC_load_value, m_pc);
        chk({tag, ".fcount"}, Fault_count, m_fc);
        chk({tag, ".fatal"}, Fatal, m_fatal);
    endtask

    task automatic check_fatal(input string tag);
        chk({tag, ".fatal"}, Fatal, 1);
        chk({tag, ".stall"}, Stall, 1);
        chk({tag, ".en"}, Resync_en, 0);
        chk({tag, ".load"}, PC_load, 0);
        chk({tag, ".fcount"}, Fault_count, m_fc);
        chk({tag, ".state"}, Ctrl_state, ST_FATAL);
    endtask

    task automatic quiet_inputs();
        Voter_state = 3'b111; Recovery_mode = 1'b0;
    endtask

    task automatic nstep(input bit noisy);
        if (noisy) begin
            Voter_state   = 3'($urandom_range(0, 7));
            Recovery_mode = 1'($urandom_range(0, 1));
        end
        step();
    endtask

    task automatic reset_dut();
        rst_in = 1'b1; quiet_inputs();
        step();
        rst_in = 1'b0;
        m_retry = 0; m_clean = 0; m_fc = 0; m_fatal = 0;
        m_src = 2'd0; m_dst = 3'd0; m_pc = 32'd0;
        check_outs("reset", 0, 0, 0, 0);
        chk("reset.state", Ctrl_state, ST_IDLE);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            m_clean++;
            if (m_clean >= CLEAN_WIN) m_retry = 0;
            check_outs("idle", 0, 0, 0, 0);
        end
    endtask

    task automatic fatal_hold(input int n);
        for (int k = 0; k < n; k++) begin
            nstep(1);
            check_fatal("fatal_hold");
        end
        quiet_inputs();
    endtask

    // One detection in IDLE followed by the full expected recovery sequence
    task automatic detect(input logic [2:0] vs, input bit rm, input logic [31:0] pc,
                          input logic [31:0] rb, input bit noisy);
        bit is_rb;
        Voter_state = vs; Recovery_mode = rm; PC_Top = pc; PC_Top_rollback = rb;
        step();
        quiet_inputs();
        PC_Top = $urandom; PC_Top_rollback = $urandom;
        is_rb = rm || (vs inside {3'b000, 3'b011, 3'b101, 3'b110});
        m_clean = 0;
        m_fc = (m_fc < 255) ? m_fc + 1 : 255;
        if (m_retry == RETRY_LIMIT) begin
            m_fatal = 1;
            check_fatal("det.fatal");
            return;
        end
        m_retry++;
        if (is_rb) begin
            m_pc = rb;
            check_outs("rollback", 1, 0, 0, 1);
        end else begin
            case (vs)
                3'b100:  begin m_dst = 3'b001; m_src = 2'd0; end
                3'b010:  begin m_dst = 3'b100; m_src = 2'd1; end
                default: begin m_dst = 3'b010; m_src = 2'd0; end
            endcase
            m_pc = pc;
            for (int i = 1; i <= 31; i++) begin
                check_outs("resync", 1, 1, i, 0);
                nstep(noisy);
            end
            check_outs("pcload", 1, 0, 0, 1);
        end
        nstep(noisy);
        check_outs("settle", 1, 0, 0, 0);
        nstep(noisy);
        quiet_inputs();
        check_outs("back_idle", 0, 0, 0, 0);
    endtask

    initial begin
        rst_in = 1'b1; quiet_inputs(); PC_Top = 32'd0; PC_Top_rollback = 32'd0;
        reset_dut();

        // Single faulty core C, then rollback on no-majority flag
        detect(3'b100, 1'b0, 32'h1234_5678, 32'h0000_DEAD, 1'b0);
        chk("req037.fcount", Fault_count, 1);
        idle(CLEAN_WIN);
        detect(3'b111, 1'b1, 32'hFFFF_0000, 32'h0000_0040, 1'b0);
        idle(CLEAN_WIN);

        // Noise ignored during recovery; clean window forgives history
        detect(3'b010, 1'b0, 32'hCAFE_0000, 32'h0, 1'b1);
        idle(CLEAN_WIN);
        for (int k = 0; k < RETRY_LIMIT; k++) begin
            detect(3'b000, 1'b0, 32'h0, 32'h100 + 32'(k), 1'b0);
            chk("req041.nofatal", Fatal, 0);
            idle(2);
        end
        detect(3'b001, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("req041.escalate", Fatal, 1);
        fatal_hold(3);

        // Four back-to-back detections from reset
        reset_dut();
        detect(3'b001, 1'b0, 32'hA0, 32'h0, 1'b0);
        detect(3'b110, 1'b0, 32'h0, 32'hB0, 1'b0);
        detect(3'b111, 1'b1, 32'h0, 32'hC0, 1'b0);
        detect(3'b100, 1'b0, 32'hD0, 32'h0, 1'b0);
        chk("req039.fcount", Fault_count, 4);
        fatal_hold(5);
        reset_dut();

        // Reset arriving mid-resync
        Voter_state = 3'b100; PC_Top = 32'h55AA_55AA;
        step();
        quiet_inputs();
        for (int i = 1; i < 10; i++) step();
        chk("req040.addr", Resync_addr, 10);
        reset_dut();

        // Randomized detections and idle gaps
        for (int k = 0; k < 150; k++) begin
            logic [2:0] vs;
            bit rm;
            if (m_fatal) begin
                fatal_hold(2);
                reset_dut();
            end else begin
                vs = 3'($urandom_range(0, 7));
                rm = (vs == 3'b111) ? 1'b1 : ($urandom_range(0, 3) == 0);
                detect(vs, rm, $urandom, $urandom, 1'($urandom_range(0, 1)));
                if (!m_fatal) idle($urandom_range(0, 20));
            end
        end

        // Fault counter saturation
        reset_dut();
        for (int k = 0; k < 258; k++) begin
            detect(3'b000, 1'b0, 32'h0, 32'(k) * 32'd4, 1'b0);
            idle(CLEAN_WIN);
        end
        chk("saturate.fcount", Fault_count, 255);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tmr_recovery_ctrl.md
TMR_RECOVERY_CTRL -- requirements
Module: tmr_recovery_ctrl

Interface
REQ-001 Parameter RETRY_LIMIT, default 3, maximum consecutive recoveries before the block declares a fatal fault.
REQ-002 Parameter CLEAN_WIN, default 16, count of consecutive clean IDLE cycles that clears the retry counter.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst_in  input  1  reset, synchronous and active-high.
REQ-005 Port Voter_state  input  3  per-pair agreement {AB,BC,AC} from the voter.
REQ-006 Port Recovery_mode  input  1  voter's no-majority flag.
REQ-007 Port PC_Top  input  32  voted PC.
REQ-008 Port PC_Top_rollback  input  32  checkpointed PC from the voter's PC buffer.
REQ-009 Port Stall  output  1  freezes all three cores.
REQ-010 Port Resync_en  output  1  register-file copy strobe.
REQ-011 Port Resync_addr  output  5  register index being copied.
REQ-012 Port Resync_src  output  2  healthy source core: 0=A, 1=B, 2=C.
REQ-013 Port Resync_dst  output  3  one-hot faulty destination core {A,B,C}.
REQ-014 Port PC_load  output  1  one-cycle PC overwrite strobe to all cores.
REQ-015 Port PC_load_value  output  32  PC to load.
REQ-016 Port Fault_count  output  8  saturating count of recovery entries.
REQ-017 Port Fatal  output  1  sticky unrecoverable-fault flag.
REQ-018 Port Ctrl_state  output  3  FSM state encoding, for debug.

Function
REQ-019 FSM states SHALL be IDLE, RESYNC, PCLOAD, SETTLE, ROLLBACK and FATAL.
REQ-020 In IDLE, Voter_state 3'b111 with Recovery_mode=0 SHALL keep the FSM in IDLE with all strobes low.
REQ-021 In IDLE, Voter_state 100, 010 or 001 SHALL latch the faulty core (C, A, B respectively), the source (A, B, A respectively) and PC_Top, then enter RESYNC on the next edge.
REQ-022 In IDLE, Voter_state 000, 011, 101 or 110, or Recovery_mode=1, SHALL latch PC_Top_rollback and enter ROLLBACK; this rule has priority over REQ-021.
REQ-023 In RESYNC, Resync_en SHALL be high for exactly 31 cycles, with Resync_addr stepping 1..31 (x0 skipped), then the FSM SHALL enter PCLOAD.
REQ-024 PCLOAD and ROLLBACK SHALL each last one cycle with PC_load=1 and PC_load_value equal to the latched PC, then enter SETTLE.
REQ-025 SETTLE SHALL last one cycle and then return to IDLE.
REQ-026 Stall SHALL be 1 in every state except IDLE; Stall SHALL be 1 continuously in FATAL.
REQ-027 Voter_state and Recovery_mode SHALL be ignored outside IDLE.
REQ-028 Each IDLE-to-RESYNC or IDLE-to-ROLLBACK transition SHALL increment Fault_count, saturating at 255, and increment the retry counter.
REQ-029 The retry counter SHALL clear after CLEAN_WIN consecutive IDLE cycles with Voter_state=111.
REQ-030 A detection in IDLE while the retry counter equals RETRY_LIMIT SHALL enter FATAL instead of recovering; Fault_count SHALL still increment.
REQ-031 Once Fatal=1, it and the FATAL state SHALL be held until reset.
REQ-032 Resync_src, Resync_dst and PC_load_value SHALL hold their latched values until the next detection, and SHALL be 0 until the first detection.

Reset
REQ-033 While rst_in=1 at a clock edge, the FSM SHALL go to IDLE and every output, counter and latch SHALL go to 0, including when reset arrives mid-RESYNC or in FATAL.
REQ-034 On the first edge after rst_in falls, the FSM SHALL evaluate Voter_state normally.

Structure
REQ-035 A shared package SHALL hold the FSM state encodings, the core-ID constants (A=0, B=1, C=2) and the register-file size of 32.
REQ-036 The retry/clean-window counter pair SHALL be one sub-module, tmr_retry_counter.

Verification
REQ-037 Voter_state=100 for one cycle in IDLE -> Resync_dst=001, Resync_src=0, 31 Resync_en pulses with addr 1..31, then PC_load with the latched PC, Fault_count=1.
REQ-038 Recovery_mode=1 and PC_Top_rollback=0x0000_0040 -> PC_load=1 with value 0x40 in the next cycle, Stall high for 2 cycles.
REQ-039 Four detections with no clean window between them (RETRY_LIMIT=3) -> fourth detection gives Fatal=1, Stall stuck at 1, Fault_count=4.
REQ-040 rst_in pulsed at RESYNC addr 10 -> next cycle in IDLE, all outputs 0.
REQ-041 Voter_state toggled to 010 during RESYNC -> ignored; after SETTLE with 16 cycles of 111, the retry counter reads 0.
